vga_fb_arbiter: RTL

- Controller for the 40x30 VGA framebuffer RAM's single read/write port (WA1/WD/WE/RD1).
- Shares that port between three requesters:
  - MCU pixel writes,
  - MCU pixel readback,
  - a hardware rectangle-fill engine used for screen clear and box draws.
- Converts (row, col) to the framebuffer address: addr = {row[4:0], col[5:0]}.
- The display-scan read port (RA2) is untouched by this block.

---
 rtl/vga_fb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Arbiter for the 40x30 framebuffer RAM port: MCU writes, MCU readback and a
// rectangle-fill engine share one read/write port with fixed priority.
module vga_fb_arbiter #(
  parameter int unsigned COLS  = 40,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COL_W = 6,
  parameter int unsigned ROW_W = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WR_REQ,
  input  logic [ROW_W-1:0]       WR_ROW,
  input  logic [COL_W-1:0]       WR_COL,
  input  logic [7:0]             WR_DATA,
  output logic                   WR_ACK,
  input  logic                   RD_REQ,
  input  logic [ROW_W-1:0]       RD_ROW,
  input  logic [COL_W-1:0]       RD_COL,
  output logic                   RD_ACK,
  output logic [7:0]             RD_DATA,
  output logic                   RD_VALID,
  input  logic                   FILL_START,
  input  logic [ROW_W-1:0]       FILL_R0,
  input  logic [COL_W-1:0]       FILL_C0,
  input  logic [ROW_W-1:0]       FILL_R1,
  input  logic [COL_W-1:0]       FILL_C1,
  input  logic [7:0]             FILL_COLOR,
  output logic                   FILL_BUSY,
  output logic                   FILL_DONE,
  output logic                   FILL_ERR,
  output logic                   FB_WE,
  output logic [ROW_W+COL_W-1:0] FB_ADDR,
  output logic [7:0]             FB_WD,
  input  logic [7:0]             FB_RD
);

  localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] COL_LIM = COL_W'(COLS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_e;

  state_e           state_q;
  logic [ROW_W-1:0] r1_q, row_q;
  logic [COL_W-1:0] c0_q, c1_q, col_q;
  logic [7:0]       color_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q, fill_busy_q, fill_done_q, fill_err_q;

  logic wr_ok, rd_ok, fill_ok;
  logic wr_grant, rd_grant, fill_step;

  assign wr_ok   = (WR_ROW < ROW_LIM) && (WR_COL < COL_LIM);
  assign rd_ok   = (RD_ROW < ROW_LIM) && (RD_COL < COL_LIM);
  assign fill_ok = (FILL_R0 <= FILL_R1) && (FILL_C0 <= FILL_C1) &&
                   (FILL_R1 < ROW_LIM) && (FILL_C1 < COL_LIM);

  // Port grant: write > read > fill step; the fill never writes while RST is high.
  assign wr_grant  = WR_REQ;
  assign rd_grant  = RD_REQ & ~WR_REQ;
  assign fill_step = (state_q == S_FILL) & ~WR_REQ & ~RD_REQ & ~RST;

  always_comb begin
    WR_ACK  = wr_grant;
    RD_ACK  = rd_grant;
    FB_WE   = 1'b0;
    FB_ADDR = '0;
    FB_WD   = 8'h00;
    if (wr_grant) begin
      FB_WE   = wr_ok;
      FB_ADDR = {WR_ROW, WR_COL};
      FB_WD   = WR_DATA;
    end else if (rd_grant) begin
      FB_ADDR = {RD_ROW, RD_COL};
    end else if (fill_step) begin
      FB_WE   = 1'b1;
      FB_ADDR = {row_q, col_q};
      FB_WD   = color_q;
    end
  end

  // Fill FSM, cursor and registered status/readback outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      r1_q        <= '0;
      row_q       <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      col_q       <= '0;
      color_q     <= 8'h00;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
    end else begin
      rd_valid_q  <= rd_grant;
      fill_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
      if (rd_grant) begin
        rd_data_q <= rd_ok ? FB_RD : 8'h00;
      end
      case (state_q)
        S_IDLE: begin
          if (FILL_START) begin
            if (fill_ok) begin
              row_q       <= FILL_R0;
              col_q       <= FILL_C0;
              r1_q        <= FILL_R1;
              c0_q        <= FILL_C0;
              c1_q        <= FILL_C1;
              color_q     <= FILL_COLOR;
              fill_busy_q <= 1'b1;
              state_q     <= S_FILL;
            end else begin
              fill_err_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (fill_step) begin
            if (col_q == c1_q) begin
              col_q <= c0_q;
              if (row_q == r1_q) begin
                fill_busy_q <= 1'b0;
                fill_done_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign FILL_BUSY = fill_busy_q;
  assign FILL_DONE = fill_done_q;
  assign FILL_ERR  = fill_err_q;

endmodule
